// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states, parity-mode codes and the parity check helper
// shared by the parametrised UART receive path.
package uart_pkg;

  // Receiver frame-tracking states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rxState_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Returns 1 when the received parity bit disagrees with the configured mode.
  // dataXor is the XOR of all received data bits.
  function automatic logic calcParityErr(input int mode, input logic dataXor, input logic sample);
    logic sum;
    sum = dataXor ^ sample;
    case (mode)
      PARITY_EVEN: calcParityErr = sum;
      PARITY_ODD:  calcParityErr = ~sum;
      default:     calcParityErr = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: brings the asynchronous rx pin into the clock domain and
// produces the bit value the receiver FSM acts on.
// Build option: UART_RX_MAJORITY_EN selects a 2-of-3 majority over three
// consecutive synchronised samples; otherwise the synchronised bit is used as is.
module uart_rx_sampler (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rxs_o,
  output logic sample_o
);

  logic sync1_q;
  logic sync2_q;

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign rxs_o = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Keeps the two previous synchronised samples so the vote covers MID-1..MID+1
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
    end
  end

  assign sample_o = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
`else
  assign sample_o = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with start-glitch rejection,
// parity/framing error flags and a valid/ready output with sticky overrun.
// Build option: UART_RX_MAJORITY_EN moves every bit decision to MID+1 and uses
// the 2-of-3 majority sample from uart_rx_sampler.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_PT = MID + 1;
`else
  localparam int SAMPLE_PT = MID;
`endif

  logic rxs;
  logic sample;

  rxState_e             state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bitIdx_q, bitIdx_d;
  logic                 stopIdx_q, stopIdx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parErr_q, parErr_d;
  logic                 frmErr_q, frmErr_d;
  logic                 done;
  logic                 doneFrmErr;
  logic                 atMid;
  logic                 atWrap;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perrOut_q;
  logic                 ferrOut_q;
  logic                 overrun_q;

  uart_rx_sampler uSampler (
    .clk_i    (clk),
    .rst_i    (rst),
    .rx_i     (rx),
    .rxs_o    (rxs),
    .sample_o (sample)
  );

  assign atMid  = (cnt_q == CW'(SAMPLE_PT));
  assign atWrap = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Frame-tracking registers; reset abandons any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitIdx_q  <= '0;
      stopIdx_q <= 1'b0;
      shift_q   <= '0;
      parErr_q  <= 1'b0;
      frmErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitIdx_q  <= bitIdx_d;
      stopIdx_q <= stopIdx_d;
      shift_q   <= shift_d;
      parErr_q  <= parErr_d;
      frmErr_q  <= frmErr_d;
    end
  end

  // Next-state logic: one decision per bit, taken at the bit midpoint
  always_comb begin
    state_d    = state_q;
    cnt_d      = atWrap ? '0 : cnt_q + CW'(1);
    bitIdx_d   = bitIdx_q;
    stopIdx_d  = stopIdx_q;
    shift_d    = shift_q;
    parErr_d   = parErr_q;
    frmErr_d   = frmErr_q;
    done       = 1'b0;
    doneFrmErr = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = START;
        end
      end
      START: begin
        if (atMid) begin
          cnt_d = '0;
          if (!sample) begin
            state_d  = DATA;
            bitIdx_d = '0;
            parErr_d = 1'b0;
            frmErr_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (atWrap) begin
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          if (bitIdx_q == 4'(DATA_BITS - 1)) begin
            state_d   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            stopIdx_d = 1'b0;
          end else begin
            bitIdx_d = bitIdx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (atWrap) begin
          parErr_d = calcParityErr(PARITY_MODE, ^shift_q, sample);
          state_d  = STOP;
        end
      end
      STOP: begin
        if (atWrap) begin
          if (stopIdx_q == 1'(STOP_BITS - 1)) begin
            done       = 1'b1;
            doneFrmErr = frmErr_q | ~sample;
            state_d    = IDLE;
          end else begin
            frmErr_d  = frmErr_q | ~sample;
            stopIdx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output holding register: loads a finished frame unless an unaccepted word blocks it
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      perrOut_q <= 1'b0;
      ferrOut_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (valid_q && rx_ready) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (done) begin
        if (!valid_q || rx_ready) begin
          data_q    <= shift_q;
          perrOut_q <= parErr_q;
          ferrOut_q <= doneFrmErr;
          valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perrOut_q;
  assign frame_err  = ferrOut_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: drives one serial line into an even-parity and an
// odd-parity receiver; expected words are queued when a frame is sent and
// popped by per-receiver monitors whenever a word is handed over.
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic rxReady;

  logic [7:0] evenData, oddData;
  logic evenValid, evenPerr, evenFerr, evenOverrun, evenBusy;
  logic oddValid, oddPerr, oddFerr, oddOverrun, oddBusy;

  int compared   = 0;
  int mismatched = 0;

  logic [9:0] evenQ[$];
  logic [9:0] oddQ[$];
  logic [9:0] evenExp;
  logic [9:0] oddExp;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dutEven (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rxReady),
    .rx_data(evenData), .rx_valid(evenValid), .parity_err(evenPerr),
    .frame_err(evenFerr), .overrun(evenOverrun), .busy(evenBusy)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dutOdd (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rxReady),
    .rx_data(oddData), .rx_valid(oddValid), .parity_err(oddPerr),
    .frame_err(oddFerr), .overrun(oddOverrun), .busy(oddBusy)
  );

  // Reference: parity error from the total count of ones, framing error from the stop bit
  function automatic logic [9:0] modelWord(input int mode, input logic [7:0] d,
                                           input logic pBit, input logic stopBit);
    int ones;
    logic pe;
    ones = $countones(d) + int'(pBit);
    if (mode == 1) pe = (ones % 2) != 0;
    else           pe = (ones % 2) == 0;
    return {~stopBit, pe, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sendBit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic pBit, input logic stopBit,
                               input int gapBits, input bit deliver);
    if (deliver) begin
      evenQ.push_back(modelWord(1, d, pBit, stopBit));
      oddQ.push_back(modelWord(2, d, pBit, stopBit));
    end
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
    sendBit(pBit);
    sendBit(stopBit);
    repeat (gapBits) sendBit(1'b1);
  endtask

  // Even-parity receiver monitor
  always @(negedge clk) begin
    if (evenValid === 1'b1 && rxReady === 1'b1) begin
      if (evenQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL evenUnexpectedWord: actual=%0h required=none", {evenFerr, evenPerr, evenData});
      end else begin
        evenExp = evenQ.pop_front();
        checkOutput("evenWord", 32'({evenFerr, evenPerr, evenData}), 32'(evenExp));
      end
    end
  end

  // Odd-parity receiver monitor
  always @(negedge clk) begin
    if (oddValid === 1'b1 && rxReady === 1'b1) begin
      if (oddQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL oddUnexpectedWord: actual=%0h required=none", {oddFerr, oddPerr, oddData});
      end else begin
        oddExp = oddQ.pop_front();
        checkOutput("oddWord", 32'({oddFerr, oddPerr, oddData}), 32'(oddExp));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic stopBit;
    int gap;

    rst = 1'b1;
    rx = 1'b1;
    rxReady = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("resetEven", 32'({evenData, evenValid, evenPerr, evenFerr, evenOverrun, evenBusy}), 32'd0);
    checkOutput("resetOdd", 32'({oddData, oddValid, oddPerr, oddFerr, oddOverrun, oddBusy}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) sendBit(1'b1);

    $display("[TB] directed frames");
    applyStimulus(8'h03, 1'b0, 1'b1, 1, 1'b1);
    applyStimulus(8'h03, 1'b1, 1'b1, 1, 1'b1);
    applyStimulus(8'hA5, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus(8'h5A, 1'b0, 1'b1, 0, 1'b1);
    applyStimulus(8'hC7, 1'b1, 1'b1, 1, 1'b1);

    $display("[TB] start-bit glitch");
    rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rx = 1'b1;
    @(negedge clk);
    checkOutput("glitchBusyHigh", 32'({evenBusy, oddBusy}), 32'b11);
    for (int i = 0; i < 16 && (evenBusy || oddBusy); i++) @(negedge clk);
    checkOutput("glitchBusyLow", 32'({evenBusy, oddBusy}), 32'b00);
    @(posedge clk);
    #1;
    sendBit(1'b1);

    $display("[TB] overrun");
    rxReady = 1'b0;
    applyStimulus(8'h11, 1'b0, 1'b1, 1, 1'b1);
    applyStimulus(8'h22, 1'b0, 1'b1, 1, 1'b0);
    @(negedge clk);
    checkOutput("overrunSet", 32'({evenOverrun, oddOverrun}), 32'b11);
    checkOutput("overrunHeldData", 32'({evenData, oddData}), 32'h1111);
    checkOutput("overrunValid", 32'({evenValid, oddValid}), 32'b11);
    @(posedge clk);
    #1;
    rxReady = 1'b1;
    @(posedge clk);
    #1;
    rxReady = 1'b0;
    @(negedge clk);
    checkOutput("overrunClearValid", 32'({evenValid, oddValid}), 32'b00);
    checkOutput("overrunClear", 32'({evenOverrun, oddOverrun}), 32'b00);
    @(posedge clk);
    #1;
    rxReady = 1'b1;

    $display("[TB] reset mid-frame");
    sendBit(1'b0);
    repeat (3) sendBit(1'b1);
    rx = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midResetEven", 32'({evenData, evenValid, evenPerr, evenFerr, evenOverrun, evenBusy}), 32'd0);
    checkOutput("midResetOdd", 32'({oddData, oddValid, oddPerr, oddFerr, oddOverrun, oddBusy}), 32'd0);
    @(posedge clk);
    #1;
    repeat (2) sendBit(1'b1);
    applyStimulus(8'h3C, 1'b0, 1'b1, 1, 1'b1);

    $display("[TB] random frames");
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom_range(0, 255));
      stopBit = ($urandom_range(0, 4) != 0);
      gap = stopBit ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      applyStimulus(d, 1'($urandom_range(0, 1)), stopBit, gap, 1'b1);
    end
    sendBit(1'b1);

    for (int i = 0; i < 64 && (evenQ.size() != 0 || oddQ.size() != 0); i++) @(negedge clk);
    checkOutput("drainEven", 32'(evenQ.size()), 32'd0);
    checkOutput("drainOdd", 32'(oddQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the successor to the fixed 8-bit, fixed-baud receive path feeding the `risk_v_multicycle` UART peripheral. It adds configurable data width, parity mode, stop-bit count and bit period. It also adds start-bit glitch rejection, per-frame parity/framing error flags, and a valid/ready output with overrun detection. It sits between the `rx` pin and the processor's memory-mapped UART registers.

## Interface
- CLKS_PER_BIT, 5208, clock cycles per bit; ≥8 (50 MHz / 9600 Bd)
- DATA_BITS, 8, data bits per frame, 5..9, LSB first
- PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, stop bits checked, 1..2
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial line, idle high
- rx_ready  in  1  consumer accepts current word
- rx_data  out  DATA_BITS  received word
- rx_valid  out  1  rx_data/parity_err/frame_err valid
- parity_err  out  1  parity mismatch for held word (0 when PARITY_MODE=0)
- frame_err  out  1  a checked stop bit sampled low for held word
- overrun  out  1  sticky: a frame completed while previous word unaccepted
- busy  out  1  FSM not in IDLE

## Operation
- `rx` passes through a 2-flop synchroniser, named rxs below; its reset value is 1.
- Bit counter: 0..CLKS_PER_BIT-1. MID = CLKS_PER_BIT/2 (integer division).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rxs is 0 → START, counter cleared.
- START:
  - at counter == MID, sample the bit.
  - sample 0 → DATA, counter cleared, bit index 0.
  - sample 1 → IDLE (glitch rejected, nothing reported).
- DATA: each time the counter wraps from CLKS_PER_BIT-1 to 0 (the next bit's midpoint), sample the bit and shift it in LSB first. After DATA_BITS samples → PARITY if PARITY_MODE≠0, else STOP.
- PARITY:
  - one sample.
  - error if XOR(data, sample) ≠ 0 for even parity.
  - error if XOR(data, sample) ≠ 1 for odd parity.
- STOP:
  - STOP_BITS samples; any 0 sample sets the frame error.
  - after the last stop sample → IDLE, and the result is delivered the same cycle.
- Delivery: frames with errors are still delivered.
  - rx_valid=0, or rx_ready=1 in the same cycle: rx_data, parity_err and frame_err load and rx_valid is 1 on the next cycle.
  - rx_valid=1 and rx_ready=0: the new frame is dropped, the old word is held and overrun is set.
- rx_valid clears on the cycle after rx_valid & rx_ready, unless a new frame loads in that same cycle.
- overrun clears on the cycle after rx_valid & rx_ready.
- Reset mid-frame: FSM → IDLE and the partial frame is discarded.
  - outputs after reset: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.

## Timing
- Pin to START: 2 cycles (synchroniser) + 1 cycle FSM.
- Each sample is taken at bit-midpoint ± 1 cycle of synchroniser skew.
- rx_valid rises 1 cycle after the final stop-bit sample (+1 with majority vote).
- This is about (1 + DATA_BITS + P + STOP_BITS − 0.5)·CLKS_PER_BIT + 4 cycles after the start-bit falling edge. P = 1 if parity is enabled, else 0.
- Back-to-back frames: IDLE is re-entered at the middle of the last stop bit. A start edge arriving immediately after that is captured, so no frame is lost.
- busy is high from START entry until the IDLE return.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - every sample is the 2-of-3 majority of rxs at counter MID-1, MID and MID+1.
  - the decision is acted on at MID+1.
  - the same applies to the start-bit check.
- `UART_RX_MAJORITY_EN` undefined: single sample at MID.

## Structure
- `uart_pkg`: FSM state enum, PARITY_NONE/EVEN/ODD constants, and a parity function.
- Sub-module `uart_rx_sampler`: the 2-flop synchroniser plus the optional majority-vote shift register. It outputs rxs and the voted sample bit.
- FSM, counters and output register live in `uart_rx_param`.

## Test plan
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, PARITY_MODE=1 (even), STOP_BITS=1 unless stated.
- Send 0x03 with parity bit 0 and stop 1, rx_ready=1 → rx_data=0x03, rx_valid one cycle, parity_err=0, frame_err=0.
- Send 0x03 with parity bit 1 → rx_data=0x03, parity_err=1; then PARITY_MODE=2 with parity 1 → parity_err=0.
- Send 0xA5 with stop bit 0 → frame_err=1, rx_data=0xA5; the next frame 0x5A is received cleanly.
- Drive rx low for 6 cycles (less than MID), then high → no rx_valid, and busy returns to 0 within 16 cycles.
- Send 0x11 then 0x22 with rx_ready=0 → rx_data=0x11 held, overrun=1. Pulse rx_ready → rx_valid=0 and overrun=0 the next cycle.
- Assert rst during the DATA state of 0xFF → all outputs 0 and busy=0. A subsequent 0x3C is received correctly.
